// File: rtl/ac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ac_pkg
//  Description : Shared definitions for the air-conditioning controller, the
//                room thermal model and their benches. Holds the mode
//                encoding, temperature width/limit and tick counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ac_pkg;

    localparam int TEMP_W   = 5;
    localparam int TEMP_MAX = 31;
    localparam int CNT_W    = 8;

    localparam logic [1:0] MODE_DRIFT = 2'd0;
    localparam logic [1:0] MODE_HEAT  = 2'd1;
    localparam logic [1:0] MODE_COOL  = 2'd2;
    localparam logic [1:0] MODE_FAULT = 2'd3;

    // Mode implied by the actuator pair; both on is treated as a fault.
    function automatic logic [1:0] decode_mode(input logic heating, input logic cooling);
        logic [1:0] result;
        case ({heating, cooling})
            2'b10:   result = MODE_HEAT;
            2'b01:   result = MODE_COOL;
            2'b11:   result = MODE_FAULT;
            default: result = MODE_DRIFT;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_counter
//  Description : Period counter for the room model. Counts enabled cycles and
//                flags the cycle on which the count reaches period-1, then
//                wraps to zero. A clear always wins and suppresses expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_counter
    import ac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == (period - CNT_W'(1)));
    assign expire    = enable & ~clear & w_at_last;

    // Count up while enabled; restart from zero on clear, reset or expiry.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/room_temp_model.sv
`default_nettype none
// ============================================================================
//  Module      : room_temp_model
//  Description : Synthesisable thermal model of a room. Heating raises and
//                cooling lowers the temperature one degree per period; with
//                both actuators off the temperature drifts toward ambient.
//                A load strobe injects a start temperature.
//  Revision    : 1.0 - initial release
// ============================================================================
module room_temp_model
    import ac_pkg::*;
#(
    parameter int TEMP_INIT   = 18,
    parameter int AMBIENT     = 15,
    parameter int HEAT_TICKS  = 8,
    parameter int COOL_TICKS  = 8,
    parameter int DRIFT_TICKS = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              heating,
    input  logic              cooling,
    input  logic              load,
    input  logic [TEMP_W-1:0] load_value,
    output logic [TEMP_W-1:0] temperature,
    output logic              temp_valid,
    output logic              fault,
    output logic [1:0]        mode
);

    localparam logic [TEMP_W-1:0] c_TEMP_INIT    = TEMP_W'(TEMP_INIT);
    localparam logic [TEMP_W-1:0] c_AMBIENT      = TEMP_W'(AMBIENT);
    localparam logic [TEMP_W-1:0] c_TEMP_MAX     = TEMP_W'(TEMP_MAX);
    localparam logic [CNT_W-1:0]  c_HEAT_PERIOD  = CNT_W'(HEAT_TICKS);
    localparam logic [CNT_W-1:0]  c_COOL_PERIOD  = CNT_W'(COOL_TICKS);
    localparam logic [CNT_W-1:0]  c_DRIFT_PERIOD = CNT_W'(DRIFT_TICKS);

    logic [TEMP_W-1:0] r_temp;
    logic              r_valid;
    logic              r_fault;
    logic [1:0]        r_mode;

    logic [1:0]        w_next_mode;
    logic              w_mode_change;
    logic              w_at_ambient;
    logic [CNT_W-1:0]  w_period;
    logic              w_cnt_clear;
    logic              w_cnt_enable;
    logic              w_expire;
    logic              w_step;
    logic [TEMP_W-1:0] w_stepped_temp;
    logic              w_temp_moves;

    assign w_next_mode   = decode_mode(heating, cooling);
    assign w_mode_change = (w_next_mode != r_mode);
    assign w_at_ambient  = (r_temp == c_AMBIENT);

    // A mode change, a load, a fault, or sitting at ambient in drift all
    // restart the period so a fresh full period is needed before a step.
    assign w_cnt_clear  = w_mode_change | load | (r_mode == MODE_FAULT)
                        | ((r_mode == MODE_DRIFT) & w_at_ambient);
    assign w_cnt_enable = (r_mode != MODE_FAULT);

    // Select the step period belonging to the mode currently in force.
    always_comb begin
        w_period = c_DRIFT_PERIOD;
        case (r_mode)
            MODE_HEAT: w_period = c_HEAT_PERIOD;
            MODE_COOL: w_period = c_COOL_PERIOD;
            default:   w_period = c_DRIFT_PERIOD;
        endcase
    end

    tick_counter u_tick_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_cnt_clear),
        .enable (w_cnt_enable),
        .period (w_period),
        .expire (w_expire)
    );

    // The counter already suppresses expiry on clear; gating again keeps the
    // load-beats-step rule explicit at this level.
    assign w_step = w_expire & ~w_mode_change & ~load;

    // Saturating one-degree step in the direction the current mode dictates.
    always_comb begin
        w_stepped_temp = r_temp;
        case (r_mode)
            MODE_HEAT: begin
                if (r_temp != c_TEMP_MAX) begin
                    w_stepped_temp = r_temp + TEMP_W'(1);
                end
            end
            MODE_COOL: begin
                if (r_temp != '0) begin
                    w_stepped_temp = r_temp - TEMP_W'(1);
                end
            end
            MODE_DRIFT: begin
                if (r_temp < c_AMBIENT) begin
                    w_stepped_temp = r_temp + TEMP_W'(1);
                end else if (r_temp > c_AMBIENT) begin
                    w_stepped_temp = r_temp - TEMP_W'(1);
                end
            end
            default: w_stepped_temp = r_temp;
        endcase
    end

    // A saturated step still consumes the period but reports nothing.
    assign w_temp_moves = w_step & (w_stepped_temp != r_temp);

    // Mode, fault flag, temperature and the change pulse, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_temp  <= c_TEMP_INIT;
            r_mode  <= MODE_DRIFT;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_mode  <= w_next_mode;
            r_fault <= (w_next_mode == MODE_FAULT);
            if (load) begin
                r_temp  <= load_value;
                r_valid <= 1'b1;
            end else if (w_temp_moves) begin
                r_temp  <= w_stepped_temp;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign temperature = r_temp;
    assign temp_valid  = r_valid;
    assign fault       = r_fault;
    assign mode        = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_room_temp_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_room_temp_model
//  Description : Self-checking bench for room_temp_model. A cycle-level
//                reference model built on edge timestamps predicts every
//                output; directed scenarios are followed by random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_room_temp_model;

    localparam int TEMP_INIT   = 18;
    localparam int AMBIENT     = 15;
    localparam int HEAT_TICKS  = 8;
    localparam int COOL_TICKS  = 8;
    localparam int DRIFT_TICKS = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       heating;
    logic       cooling;
    logic       load;
    logic [4:0] load_value;
    logic [4:0] temperature;
    logic       temp_valid;
    logic       fault;
    logic [1:0] mode;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference state: outputs plus the edge number of the last period start.
    int m_temp;
    int m_mode;
    int m_valid;
    int m_fault;
    int t_now      = 0;
    int t_restart  = 0;

    room_temp_model #(
        .TEMP_INIT   (TEMP_INIT),
        .AMBIENT     (AMBIENT),
        .HEAT_TICKS  (HEAT_TICKS),
        .COOL_TICKS  (COOL_TICKS),
        .DRIFT_TICKS (DRIFT_TICKS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .heating     (heating),
        .cooling     (cooling),
        .load        (load),
        .load_value  (load_value),
        .temperature (temperature),
        .temp_valid  (temp_valid),
        .fault       (fault),
        .mode        (mode)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, t_now, observed, expected);
        end
    endtask

    // Advance the reference by one rising edge using the inputs in force.
    task automatic model_edge();
        int next_mode;
        int period;
        int new_temp;
        t_now++;
        next_mode = int'(heating) + 2 * int'(cooling);
        if (rst) begin
            m_temp    = TEMP_INIT;
            m_mode    = 0;
            m_valid   = 0;
            m_fault   = 0;
            t_restart = t_now;
            return;
        end
        m_valid = 0;
        period  = (m_mode == 1) ? HEAT_TICKS : (m_mode == 2) ? COOL_TICKS : DRIFT_TICKS;
        if (next_mode != m_mode || load || m_mode == 3 || (m_mode == 0 && m_temp == AMBIENT)) begin
            t_restart = t_now;
        end else if (t_now - t_restart == period) begin
            t_restart = t_now;
            new_temp  = m_temp;
            if (m_mode == 1)      new_temp = (m_temp >= 31) ? 31 : m_temp + 1;
            else if (m_mode == 2) new_temp = (m_temp <= 0) ? 0 : m_temp - 1;
            else                  new_temp = (m_temp < AMBIENT) ? m_temp + 1 : m_temp - 1;
            if (new_temp != m_temp) begin
                m_temp  = new_temp;
                m_valid = 1;
            end
        end
        if (load) begin
            m_temp  = int'(load_value);
            m_valid = 1;
        end
        m_mode  = next_mode;
        m_fault = (next_mode == 3) ? 1 : 0;
    endtask

    // One clock: update the model at the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_value("temperature", 32'(temperature), 32'(m_temp));
        check_value("temp_valid",  32'(temp_valid),  32'(m_valid));
        check_value("fault",       32'(fault),       32'(m_fault));
        check_value("mode",        32'(mode),        32'(m_mode));
    endtask

    task automatic do_load(input int value);
        load       = 1'b1;
        load_value = 5'(value);
        tick();
        load       = 1'b0;
    endtask

    initial begin
        int pulses;
        int first_at;

        rst = 1'b1; heating = 1'b0; cooling = 1'b0; load = 1'b0; load_value = '0;
        tick();
        tick();
        check_value("reset_temp", 32'(temperature), 32'd18);
        rst = 1'b0;

        // Drift from 18 to ambient 15: three steps, then hold.
        pulses = 0;
        first_at = -1;
        for (int i = 1; i <= 110; i++) begin
            tick();
            if (temp_valid) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check_value("drift_pulses", 32'(pulses), 32'd3);
        check_value("drift_first_step", 32'(first_at), 32'd32);
        check_value("drift_final", 32'(temperature), 32'd15);

        // Heat from 29 into saturation at 31 with no further pulses.
        do_load(29);
        heating = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (temp_valid) pulses++;
        end
        check_value("heat_sat_temp", 32'(temperature), 32'd31);
        check_value("heat_sat_pulses", 32'(pulses), 32'd2);
        heating = 1'b0;

        // Cool from 2 into saturation at 0, never wrapping.
        do_load(2);
        cooling = 1'b1;
        repeat (50) tick();
        check_value("cool_sat_temp", 32'(temperature), 32'd0);
        cooling = 1'b0;

        // Both actuators on: fault, temperature frozen.
        do_load(20);
        heating = 1'b1; cooling = 1'b1;
        repeat (20) tick();
        check_value("fault_temp", 32'(temperature), 32'd20);
        check_value("fault_mode", 32'(mode), 32'd3);
        heating = 1'b0; cooling = 1'b0;
        tick();
        check_value("fault_release", 32'(fault), 32'd0);

        // One-cycle heating dropout restarts the full period.
        do_load(10);
        heating = 1'b1;
        repeat (5) tick();
        heating = 1'b0;
        tick();
        heating = 1'b1;
        tick();
        first_at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (temp_valid && first_at < 0) first_at = i;
        end
        check_value("glitch_first_step", 32'(first_at), 32'd8);

        // Reset mid-period in HEAT, then full drift period after release.
        heating = 1'b0;
        do_load(25);
        heating = 1'b1;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check_value("rst_mid_temp", 32'(temperature), 32'd18);
        check_value("rst_mid_mode", 32'(mode), 32'd0);
        rst = 1'b0; heating = 1'b0;
        first_at = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (temp_valid && first_at < 0) first_at = i;
        end
        check_value("rst_first_drift", 32'(first_at), 32'd32);

        // Load landing on the same edge as a heat expiry wins.
        do_load(12);
        heating = 1'b1;
        repeat (8) tick();
        do_load(5);
        check_value("load_vs_expiry", 32'(temperature), 32'd5);
        repeat (3) tick();
        heating = 1'b0;

        // Random traffic: held actuator stretches, sparse loads and resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                heating = 1'($urandom_range(0, 1));
                cooling = ($urandom_range(0, 4) == 0) ? 1'b1 : ~heating & 1'($urandom_range(0, 1));
            end
            load       = ($urandom_range(0, 49) == 0);
            load_value = 5'($urandom_range(0, 31));
            rst        = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0; load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/room_temp_model.md
# room_temp_model

Synthesisable thermal model of the room that closes the loop around the air-conditioning controller. It consumes the controller's `heating`/`cooling` outputs and produces the 5-bit `temperature` the controller samples. Temperature rises, falls or drifts toward ambient at parameterised rates. Used in closed-loop benches and the FPGA demo, where `load` injects a start temperature.

## Interface
Parameters:
- `TEMP_INIT`, 18: temperature after reset (°C, 0–31).
- `AMBIENT`, 15: drift target when neither actuator is on.
- `HEAT_TICKS`, 8: cycles per +1 °C while heating (≥1, ≤255).
- `COOL_TICKS`, 8: cycles per −1 °C while cooling (≥1, ≤255).
- `DRIFT_TICKS`, 32: cycles per 1 °C step toward `AMBIENT` (≥1, ≤255).

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `heating` in 1: heater on (from controller).
- `cooling` in 1: cooler on (from controller).
- `load` in 1: one-cycle strobe that overwrites the temperature.
- `load_value` in 5: value written on `load`.
- `temperature` out 5: current room temperature, unsigned °C.
- `temp_valid` out 1: one-cycle pulse the cycle after `temperature` changes.
- `fault` out 1: high while `heating` and `cooling` are both asserted.
- `mode` out 2: current mode encoding.

## Operation
- Modes: DRIFT=0, HEAT=1, COOL=2, FAULT=3. Next mode each edge: {h,c}=10→HEAT, 01→COOL, 11→FAULT, 00→DRIFT.
- 8-bit tick counter `cnt`.
  - On any mode change, `cnt` is set to 0 and no step occurs that edge.
  - Otherwise, in HEAT/COOL/DRIFT, `cnt` increments each edge.
  - When `cnt == PERIOD-1` for the current mode, one step occurs and `cnt` is set to 0.
- HEAT step: +1, saturating at 31. At 31, `cnt` keeps wrapping, temperature holds and there is no `temp_valid`.
- COOL step: −1, saturating at 0. Same rule applies at 0.
- DRIFT step: ±1 toward `AMBIENT`. At `AMBIENT`, `cnt` is held at 0 and there is no step.
- FAULT: temperature is held, `cnt` is held at 0, `fault`=1.
- `load` has priority over any step:
  - `temperature`←`load_value`, `cnt`←0, `temp_valid` pulses next cycle even if the value is equal.
  - The mode updates normally in the same edge.
- `rst` has priority over everything:
  - `temperature`←`TEMP_INIT`, `cnt`←0, `mode`←DRIFT.
  - `temp_valid`←0, `fault`←0.
  - Any in-progress period is discarded; counting restarts from 0 after release.
- Arithmetic: 5-bit unsigned with explicit saturation compares. No wrap-around 31→0 or 0→31 is permitted.

## Timing
- All outputs are registered. Reset values: `temperature`=TEMP_INIT, `temp_valid`=0, `fault`=0, `mode`=0.
- Input change sampled at edge k: `mode`/`fault` are updated at edge k.
- If the mode changed at edge k, the first step occurs at edge k+PERIOD. Steady state is one step every PERIOD edges.
- `temp_valid` is asserted for exactly the cycle following an edge that changed `temperature` (or accepted `load`). It is never asserted for 2 consecutive cycles unless PERIOD=1 or `load` is repeated.
- `heating`/`cooling` glitches of one cycle reset `cnt` twice (mode change in and out). This is intended: the progress of the interrupted period is lost.
- `load` and a period expiry on the same edge: `load` wins and the step is dropped.

## Structure
- Shared package `ac_pkg`: mode localparams (MODE_DRIFT/HEAT/COOL/FAULT), `TEMP_W`=5, `TEMP_MAX`=31. The controller and benches import the same package.
- Natural sub-module: `tick_counter` (8-bit, `clear`, `enable`, `period` input, `expire` output). It is instantiated once, with `period` muxed from the mode.
- The top level holds the mode register, the saturating temperature register and the `temp_valid`/`fault` flops.

## Test plan
- Reset with defaults, h=c=0 → `temperature`=18. It decrements to 17 at edge 32 after reset release, reaches 15 after 96 edges and then holds; `temp_valid` pulses exactly 3 times.
- `load` 29, then hold `heating`=1 → 30 at +8 edges, 31 at +16 edges, then holds at 31 with no further `temp_valid` for ≥40 cycles.
- `load` 2, then hold `cooling`=1 → 1, 0 at +8/+16 edges; stays at 0 with no wrap to 31.
- h=c=1 for 20 cycles from 20 °C → `fault`=1 the cycle after the first sampled edge, `mode`=3, temperature stays 20. Release → `fault`=0.
- Heating for 5 cycles, a 1-cycle drop to 0, then heating again → the step occurs 8 edges after re-entry, not 3.
- Assert `rst` at `cnt`=6 during HEAT → temperature=18 and mode=DRIFT at the next edge. After release, the first drift step comes 32 edges later. Also: `load` coincident with an expiry → load value wins.
